elc3_mem_bridge: RTL

//   Master-side bridge in front of the 32-bit single-port on-chip RAM (1024 x 32, byteenable, 1-cycle read).

---
 rtl/elc3_mem_pkg.sv | 20 ++
 rtl/elc3_mem_bridge.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/elc3_mem_pkg.sv
// Shared definitions for the eLC-3 memory bridge: FSM encoding and RAM byte-lane masks.
package elc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_CLEAR
  } state_e;

  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  function automatic logic [3:0] half_be(input logic hi);
    return hi ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/elc3_mem_bridge.sv
// 16-bit halfword req/ack port onto a 32-bit byte-enabled single-port RAM,
// plus a clear sequencer that writes CLR_VALUE to every RAM word.
module elc3_mem_bridge
  import elc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] CLR_VALUE = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W:0]   cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              mem_clken
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              half_q, half_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    half_d  = half_q;
    addr_d  = '0;
    be_d    = '0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    wdata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        // RAM outputs are registered, so the first access of a transaction is
        // launched from here; a read's ack cycle lands in IDLE and must not
        // re-accept the still-high request.
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          we_d    = 1'b1;
          be_d    = BE_ALL;
          wdata_d = CLR_VALUE;
        end else if (cpu_req && !ack_q) begin
          half_d = cpu_addr[0];
          addr_d = cpu_addr[ADDR_W:1];
          cs_d   = 1'b1;
          if (cpu_we) begin
            state_d = ST_WR;
            we_d    = 1'b1;
            be_d    = half_be(cpu_addr[0]);
            wdata_d = {cpu_wdata, cpu_wdata};
            ack_d   = 1'b1;
          end else begin
            state_d = ST_RD_ADDR;
            be_d    = BE_ALL;
          end
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rdata_d = half_q ? mem_readdata[31:16] : mem_readdata[15:0];
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_WORD) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          cs_d    = 1'b1;
          we_d    = 1'b1;
          be_d    = BE_ALL;
          addr_d  = cnt_q + 1'b1;
          wdata_d = CLR_VALUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      half_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      half_q  <= half_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign cpu_ack        = ack_q;
  assign cpu_rdata      = rdata_q;
  assign clr_busy       = busy_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  // Tied to the reset pin so the RAM clock is enabled exactly while out of reset.
  assign mem_clken      = reset_n;

endmodule
